// File: rtl/column_scan_scheduler.sv
// -----------------------------------------------------------------------------
// column_scan_scheduler
//
// Frame sequencer for the LED-matrix column driver. For every column (outer
// loop) and every BCM bit-plane (inner loop) it:
//   1. asks the row shifter for the plane data (load_req/load_ack handshake),
//   2. holds the matrix blanked for BLANK_TICKS cycles (ghosting guard),
//   3. on the first plane of a column only, shifts the column_select chain one
//      step (select_next, with extra_bit injecting the token at column 0) and
//      waits for the chain to report ready again,
//   4. un-blanks the matrix for BASE_TICKS << plane_idx cycles.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   frame_start  : 1-cycle pulse, starts a frame (ignored while busy)
//   col_ready    : column_select idle / accepts select_next
//   select_next  : 1-cycle pulse, shift column chain
//   extra_bit    : token bit, only meaningful together with select_next
//   load_req     : request row data for (column_idx, plane_idx), held to ack
//   load_ack     : row data latched
//   blank        : 1 = matrix outputs disabled
//   column_idx   : current column
//   plane_idx    : current bit-plane
//   busy         : frame in progress
//   frame_done   : 1-cycle pulse after the last plane of the last column
//
// Build option
//   COLUMN_SCAN_AUTORESTART_EN : when defined the next frame starts right after
//   frame_done without waiting for frame_start (busy stays high). Default build
//   returns to idle and waits for frame_start.
//
// All outputs are registered; the output process computes the value each
// output takes in the state being entered, so blank is low exactly while the
// FSM sits in ON.
// -----------------------------------------------------------------------------
module column_scan_scheduler #(
  parameter int COLUMN_NUMBER = 3,
  parameter int BCM_BITS      = 4,
  parameter int BASE_TICKS    = 16,
  parameter int BLANK_TICKS   = 4,
  localparam int CW = (COLUMN_NUMBER > 1) ? $clog2(COLUMN_NUMBER) : 1,
  localparam int PW = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          col_ready,
  output logic          select_next,
  output logic          extra_bit,
  output logic          load_req,
  input  logic          load_ack,
  output logic          blank,
  output logic [CW-1:0] column_idx,
  output logic [PW-1:0] plane_idx,
  output logic          busy,
  output logic          frame_done
);

  // Longest on-time belongs to the top plane; one extra bit keeps the
  // shifted constant and the terminal count from wrapping.
  localparam int MAX_ON = BASE_TICKS << (BCM_BITS - 1);
  localparam int TW     = $clog2((MAX_ON > BLANK_TICKS) ? MAX_ON : BLANK_TICKS) + 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    BLANK  = 3'd2,
    SELECT = 3'd3,
    SETTLE = 3'd4,
    ON     = 3'd5,
    ADV    = 3'd6
  } state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick, tick_n;
  logic [TW-1:0]   on_last;
  logic [CW-1:0]   col_n;
  logic [PW-1:0]   plane_n;
  logic            last_col, last_plane;

  logic            blank_n, load_req_n, sel_n, extra_n, busy_n, done_n;

  assign last_col   = (column_idx == CW'(COLUMN_NUMBER - 1));
  assign last_plane = (plane_idx  == PW'(BCM_BITS - 1));
  // Terminal count of the ON window for the current plane.
  assign on_last    = (TW'(BASE_TICKS) << plane_idx) - TW'(1);

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick        <= '0;
      column_idx  <= '0;
      plane_idx   <= '0;
      blank       <= 1'b1;
      load_req    <= 1'b0;
      select_next <= 1'b0;
      extra_bit   <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state       <= state_n;
      tick        <= tick_n;
      column_idx  <= col_n;
      plane_idx   <= plane_n;
      blank       <= blank_n;
      load_req    <= load_req_n;
      select_next <= sel_n;
      extra_bit   <= extra_n;
      busy        <= busy_n;
      frame_done  <= done_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, index and tick counter logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n = state;
    col_n   = column_idx;
    plane_n = plane_idx;

    unique case (state)
      IDLE: begin
        if (frame_start) begin
          state_n = LOAD;
          col_n   = '0;
          plane_n = '0;
        end
      end

      LOAD: begin
        if (load_ack) state_n = BLANK;
      end

      BLANK: begin
        // The chain only moves on the first plane of a column.
        if (tick == TW'(BLANK_TICKS - 1))
          state_n = (plane_idx == '0) ? SELECT : ON;
      end

      SELECT: begin
        if (col_ready) state_n = SETTLE;
      end

      SETTLE: begin
        // select_next is high only in the first SETTLE cycle; column_select
        // may still show the stale ready there, so that cycle is skipped.
        if (!select_next && col_ready) state_n = ON;
      end

      ON: begin
        if (tick == on_last) state_n = ADV;
      end

      ADV: begin
        if (!last_plane) begin
          plane_n = plane_idx + PW'(1);
          state_n = LOAD;
        end else begin
          plane_n = '0;
          if (!last_col) begin
            col_n   = column_idx + CW'(1);
            state_n = LOAD;
          end else begin
            col_n   = '0;
`ifdef COLUMN_SCAN_AUTORESTART_EN
            state_n = LOAD;
`else
            state_n = IDLE;
`endif
          end
        end
      end

      default: state_n = IDLE;
    endcase

    // Counter restarts on every state change and only runs in the timed
    // states, so it cannot creep while stalled on a handshake.
    if (state_n != state)
      tick_n = '0;
    else if (state == BLANK || state == ON)
      tick_n = tick + TW'(1);
    else
      tick_n = tick;
  end

  // ---------------------------------------------------------------------------
  // Output logic (values for the next cycle, registered above)
  // ---------------------------------------------------------------------------
  always_comb begin
    blank_n    = (state_n != ON);
    load_req_n = (state_n == LOAD);
    busy_n     = (state_n != IDLE);
    sel_n      = (state == SELECT) && col_ready;
    extra_n    = (state == SELECT) && col_ready && (column_idx == '0);
    done_n     = (state == ADV) && last_plane && last_col;
  end

endmodule
